// File: rtl/tx_fifo_pkg.sv
// Shared constants and helpers for the TX word FIFO and the TX datapath.
package tx_fifo_pkg;

  localparam int unsigned DefaultWordLength = 34;
  localparam int unsigned DefaultDepth      = 4;
  localparam int unsigned MaxIdleWidth      = 256;

  // Idle word: the low `width` bits set; callers cast down to their word width.
  function automatic logic [MaxIdleWidth-1:0] idle_word(input int unsigned width);
    return {MaxIdleWidth{1'b1}} >> (MaxIdleWidth - width);
  endfunction

endpackage

// File: rtl/tx_fifo_mem.sv
// Depth x Word_Length register array; one write port, asynchronous read port.
module tx_fifo_mem
  import tx_fifo_pkg::*;
#(
  parameter int unsigned Word_Length = DefaultWordLength,
  parameter int unsigned Depth       = DefaultDepth,
  localparam int unsigned AddrWidth  = $clog2(Depth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [AddrWidth-1:0]   waddr_i,
  input  logic [Word_Length-1:0] wdata_i,
  input  logic [AddrWidth-1:0]   raddr_i,
  output logic [Word_Length-1:0] rdata_o
);

  localparam logic [Word_Length-1:0] IdleWord = Word_Length'(idle_word(Word_Length));

  logic [Word_Length-1:0] mem_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= IdleWord;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tx_word_fifo.sv
// First-word-fall-through TX word buffer with count, back-pressure and sticky error flags.
module tx_word_fifo
  import tx_fifo_pkg::*;
#(
  parameter int unsigned Word_Length  = DefaultWordLength,
  parameter int unsigned Depth        = DefaultDepth,
  localparam int unsigned Count_Width = $clog2(Depth) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sys_reset,
  input  logic                   push,
  input  logic [Word_Length-1:0] Data_Input,
  input  logic                   pop,
  output logic [Word_Length-1:0] Data_Output,
  output logic                   empty,
  output logic                   full,
  output logic [Count_Width-1:0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AddrWidth = $clog2(Depth);
  localparam logic [Word_Length-1:0] IdleWord = Word_Length'(idle_word(Word_Length));
  localparam logic [Count_Width-1:0] FullCount = Count_Width'(Depth);

  logic [AddrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [Count_Width-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   do_push, do_pop;
  logic [Word_Length-1:0] rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  // A push at full is still accepted when a pop frees the head in the same cycle.
  assign do_push = push && !sys_reset && (!full || pop);
  assign do_pop  = pop && !sys_reset && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (sys_reset) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AddrWidth'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AddrWidth'(1);
      if (do_push && !do_pop) count_d = count_q + Count_Width'(1);
      if (do_pop && !do_push) count_d = count_q - Count_Width'(1);
      if (push && full && !pop) overflow_d = 1'b1;
      if (pop && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  tx_fifo_mem #(
    .Word_Length (Word_Length),
    .Depth       (Depth)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (Data_Input),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign Data_Output = empty ? IdleWord : rdata;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_tx_word_fifo.sv
// Directed and randomized checks of tx_word_fifo against a queue-based reference model.
module tb_tx_word_fifo;

  localparam int unsigned W = 34;
  localparam int unsigned D = 4;
  localparam int unsigned CW = $clog2(D) + 1;
  localparam logic [W-1:0] Ones = {W{1'b1}};

  logic          clk = 1'b0;
  logic          reset;
  logic          sys_reset;
  logic          push;
  logic [W-1:0]  Data_Input;
  logic          pop;
  logic [W-1:0]  Data_Output;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int vectors = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] q[$];
  logic         m_ovf;
  logic         m_udf;

  tx_word_fifo #(
    .Word_Length (W),
    .Depth       (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sys_reset   (sys_reset),
    .push        (push),
    .Data_Input  (Data_Input),
    .pop         (pop),
    .Data_Output (Data_Output),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] exp_out;
    exp_out = (q.size() == 0) ? Ones : q[0];
    check({tag, ".data"},  Data_Output, exp_out);
    check({tag, ".count"}, W'(count), W'(q.size()));
    check({tag, ".empty"}, W'(empty), W'(q.size() == 0));
    check({tag, ".full"},  W'(full), W'(q.size() == D));
    check({tag, ".ovf"},   W'(overflow), W'(m_ovf));
    check({tag, ".udf"},   W'(underflow), W'(m_udf));
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Apply one clock of stimulus; the model advances on the pre-edge occupancy.
  task automatic step(input logic p, input logic [W-1:0] d, input logic o, input logic s,
                      input string tag);
    bit was_full, was_empty;
    push = p; Data_Input = d; pop = o; sys_reset = s;
    if (s) begin
      model_clear();
    end else begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      if (p && was_full && !o) m_ovf = 1'b1;
      if (o && was_empty) m_udf = 1'b1;
      if (o && !was_empty) void'(q.pop_front());
      if (p && (!was_full || o)) q.push_back(d);
    end
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; sys_reset = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] rd;
    reset = 1'b1; sys_reset = 1'b0; push = 1'b0; pop = 1'b0; Data_Input = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all("por");

    // Put something in, then assert reset mid-cycle with push held high
    step(1'b1, 34'h2_5555_AAAA, 1'b0, 1'b0, "pre_rst");
    push = 1'b1; Data_Input = 34'h1_1111_1111;
    #3 reset = 1'b1;
    #1 model_clear();
    check_all("async_rst");
    @(posedge clk);
    #1 reset = 1'b0; push = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, "rst_idle");

    step(1'b1, 34'h0_0000_00A5, 1'b0, 1'b0, "single_wr");
    step(1'b0, '0, 1'b1, 1'b0, "single_rd");

    // Fill to full, then attempt an overflowing push
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0, 1'b0, "fill");
    step(1'b1, W'(5), 1'b0, 1'b0, "overflow");
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");
    check("word5_gone", Data_Output, Ones);

    // Pass-through at full is legal
    step(1'b0, '0, 1'b0, 1'b1, "flush0");
    for (int i = 0; i < 4; i++) step(1'b1, W'(16 + i), 1'b0, 1'b0, "refill");
    step(1'b1, W'(99), 1'b1, 1'b0, "full_passthru");
    step(1'b0, '0, 1'b0, 1'b1, "flush1");

    // Simultaneous traffic across pointer wrap
    step(1'b1, W'(100), 1'b0, 1'b0, "prefill");
    step(1'b1, W'(101), 1'b0, 1'b0, "prefill");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, W'(102 + i), 1'b1, 1'b0, "wrap");
      check("wrap_seq", Data_Output, W'(101 + i));
    end
    step(1'b0, '0, 1'b1, 1'b0, "wrap_drain");
    step(1'b0, '0, 1'b1, 1'b0, "wrap_drain");

    step(1'b0, '0, 1'b1, 1'b0, "underflow");
    step(1'b1, 34'h1_2345_6789, 1'b1, 1'b0, "push_pop_empty");

    // Flush with count = 3 and overflow set, push/pop active in the same cycle
    step(1'b0, '0, 1'b0, 1'b1, "flush2");
    for (int i = 0; i < 4; i++) step(1'b1, W'(200 + i), 1'b0, 1'b0, "fill2");
    step(1'b1, W'(250), 1'b0, 1'b0, "ovf2");
    step(1'b0, '0, 1'b1, 1'b0, "to3");
    step(1'b1, W'(300), 1'b1, 1'b1, "sys_reset");
    step(1'b1, 34'h3_0F0F_0F0F, 1'b0, 1'b0, "post_flush");

    // Randomized traffic, occasional flush
    for (int i = 0; i < 400; i++) begin
      rd = {2'($urandom_range(3)), 32'($urandom)};
      step(1'($urandom_range(1)), rd, 1'($urandom_range(1)), ($urandom_range(49) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
